// File: rtl/i2c_bus_pkg.sv
// Purpose: shared types, default constants and condition helpers for the I2C receive conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   bus_state_t         bus FSM encoding (BUS_IDLE / BUS_BUSY)
//   DEF_*               default parameter values for the conditioner
//   is_start / is_stop  SDA edge while SCL held high in both cycles
package i2c_bus_pkg;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_FILTER_LEN      = 4;
    localparam int DEF_BUS_FREE_CYCLES = 470;  // 4.7 us at 100 MHz

    // SCL must be high in both the previous and the current cycle.
    // If SCL moved in the same cycle as SDA, the SCL edge takes precedence
    // and no bus condition is reported.
    function automatic logic is_start(input logic scl_prev, input logic scl_now,
                                      input logic sda_prev, input logic sda_now);
        return scl_prev & scl_now & sda_prev & ~sda_now;
    endfunction

    function automatic logic is_stop(input logic scl_prev, input logic scl_now,
                                     input logic sda_prev, input logic sda_now);
        return scl_prev & scl_now & ~sda_prev & sda_now;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Purpose: synchronise one asynchronous I2C line and suppress pulses shorter than FILTER_LEN cycles.
// Latency: SYNC_STAGES + FILTER_LEN clk edges from input step to line_filt change.
// Backpressure: none; the filtered level is always valid.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset (sync flops and line_filt reset to 1, counter to 0)
//   line_in    raw asynchronous line level
//   line_filt  synchronised, glitch-filtered level
module i2c_line_filter
    import i2c_bus_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,  // >= 2
    parameter int FILTER_LEN  = DEF_FILTER_LEN    // >= 1
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_filt
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_out;
    logic                   filt_q;

    // Idle I2C lines are high, so resetting to 1 avoids a spurious edge
    // when a quiet bus comes out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The counter tracks how long the synchronised level has disagreed with
    // the filtered level. Any agreement restarts the count, so only a level
    // that holds for FILTER_LEN consecutive cycles gets through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_out == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_q <= ~filt_q;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign line_filt = filt_q;

endmodule

// File: rtl/i2c_bus_cond_detector.sv
// Purpose: conditions received SCL/SDA and reports edges, START/STOP/rSTART, bus busy/free and sampled bits.
// Latency: SYNC_STAGES+FILTER_LEN edges to scl/sda_filt, +1 to pulses, +1 more to bus_busy.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
//
// Ports:
//   clk, rst              system clock, asynchronous active-low reset
//   scl_in, sda_in        raw (delayed) bus lines, asynchronous
//   scl_filt, sda_filt    synchronised, filtered lines
//   scl_rise, scl_fall    1-cycle SCL edge pulses
//   start_det, rstart_det 1-cycle START; rstart_det additionally when the bus was already busy
//   stop_det              1-cycle STOP
//   bus_busy, bus_free    bus state levels
//   bit_valid, bit_data   sampled SDA on each SCL rise while busy; bit_data holds between samples
module i2c_bus_cond_detector
    import i2c_bus_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int FILTER_LEN      = DEF_FILTER_LEN,
    parameter int BUS_FREE_CYCLES = DEF_BUS_FREE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic rstart_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_free,
    output logic bit_valid,
    output logic bit_data
);

    localparam int FREE_W = $clog2(BUS_FREE_CYCLES + 1);
    localparam logic [FREE_W-1:0] FREE_MAX = FREE_W'(BUS_FREE_CYCLES);

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filter (
        .clk       (clk),
        .rst       (rst),
        .line_in   (scl_in),
        .line_filt (scl_filt)
    );

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filter (
        .clk       (clk),
        .rst       (rst),
        .line_in   (sda_in),
        .line_filt (sda_filt)
    );

    // ------------------------------------------------------------------
    // Edge and bus-condition detection
    // ------------------------------------------------------------------
    logic scl_prev;
    logic sda_prev;
    logic scl_rise_c;
    logic scl_fall_c;
    logic start_c;
    logic stop_c;

    bus_state_t      state_q;
    bus_state_t      state_d;
    logic [FREE_W-1:0] free_cnt_q;

    assign scl_rise_c = scl_filt & ~scl_prev;
    assign scl_fall_c = ~scl_filt & scl_prev;
    assign start_c    = is_start(scl_prev, scl_filt, sda_prev, sda_filt);
    assign stop_c     = is_stop(scl_prev, scl_filt, sda_prev, sda_filt);

    // Previous-cycle copies reset high to match the filter reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_filt;
            sda_prev <= sda_filt;
        end
    end

    // All pulses are registered so downstream FSMs see glitch-free strobes.
    // rstart_det and bit_valid look at the state before this edge, so a
    // START that opens a transfer is never flagged as a repeated START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            start_det  <= 1'b0;
            rstart_det <= 1'b0;
            stop_det   <= 1'b0;
            bit_valid  <= 1'b0;
            bit_data   <= 1'b0;
        end else begin
            scl_rise   <= scl_rise_c;
            scl_fall   <= scl_fall_c;
            start_det  <= start_c;
            rstart_det <= start_c & (state_q == BUS_BUSY);
            stop_det   <= stop_c;
            bit_valid  <= scl_rise_c & (state_q == BUS_BUSY);
            if (scl_rise_c && (state_q == BUS_BUSY)) begin
                bit_data <= sda_filt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus state FSM
    // Driven from the registered pulses, so bus_busy follows start_det by
    // one cycle. An SCL fall while idle means we joined a transfer already
    // in progress (e.g. after a reset mid-byte) and must treat it as busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: begin
                if (start_det || scl_fall) begin
                    state_d = BUS_BUSY;
                end
            end
            BUS_BUSY: begin
                if (stop_det) begin
                    state_d = BUS_IDLE;
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    assign bus_busy = (state_q == BUS_BUSY);

    // ------------------------------------------------------------------
    // Bus-free timer: both lines high and idle for BUS_FREE_CYCLES.
    // Starts from zero after reset, so a freshly reset block waits the
    // full tBUF before declaring the bus free.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_cnt_q <= '0;
        end else if ((state_q != BUS_IDLE) || !scl_filt || !sda_filt) begin
            free_cnt_q <= '0;
        end else if (free_cnt_q != FREE_MAX) begin
            free_cnt_q <= free_cnt_q + FREE_W'(1);
        end
    end

    assign bus_free = (free_cnt_q == FREE_MAX);

endmodule

// File: tb/tb_i2c_bus_cond_detector.sv
module tb_i2c_bus_cond_detector;

    logic clk;
    logic rst;
    logic scl_in;
    logic sda_in;
    logic scl_filt;
    logic sda_filt;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic rstart_det;
    logic stop_det;
    logic bus_busy;
    logic bus_free;
    logic bit_valid;
    logic bit_data;

    i2c_bus_cond_detector dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .scl_filt   (scl_filt),
        .sda_filt   (sda_filt),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .rstart_det (rstart_det),
        .stop_det   (stop_det),
        .bus_busy   (bus_busy),
        .bus_free   (bus_free),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse flag vector: {scl_rise, scl_fall, start, rstart, stop, bit_valid}
    localparam logic [5:0] F_RISE   = 6'b100000;
    localparam logic [5:0] F_FALL   = 6'b010000;
    localparam logic [5:0] F_START  = 6'b001000;
    localparam logic [5:0] F_RSTART = 6'b000100;
    localparam logic [5:0] F_STOP   = 6'b000010;
    localparam logic [5:0] F_BV     = 6'b000001;
    localparam int         LAT      = 7;  // input step -> registered pulse

    typedef struct packed {
        logic [5:0] flags;
        logic       bd;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  tests  = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input logic [5:0] f, input logic b, input int dly);
        ev_t e;
        e.flags = f;
        e.bd    = b;
        e.cyc   = cyc + dly;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every cycle with any pulse asserted must match the head of
    // the expected-event queue in flags, bit value and cycle number.
    logic [5:0] mon_flags;
    ev_t        mon_exp;
    always @(negedge clk) begin
        mon_flags = {scl_rise, scl_fall, start_det, rstart_det, stop_det, bit_valid};
        if (mon_flags != 6'b0) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got flags=%b at cycle %0d, required no pulse",
                         mon_flags, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_flags != mon_exp.flags || cyc != mon_exp.cyc ||
                    (mon_exp.flags[0] && bit_data != mon_exp.bd)) begin
                    errors++;
                    $display("FAIL pulse_event: got flags=%b bd=%b cycle=%0d, required flags=%b bd=%b cycle=%0d",
                             mon_flags, bit_data, cyc, mon_exp.flags, mon_exp.bd, mon_exp.cyc);
                end
            end
        end
    end

    initial begin
        logic [7:0] byte_val;
        int s;

        // ---- 1: reset with idle lines, then tBUF after release ----
        rst    = 1'b0;
        scl_in = 1'b1;
        sda_in = 1'b1;
        wait_cyc(3);
        check("rst_scl_filt", scl_filt, 1);
        check("rst_sda_filt", sda_filt, 1);
        check("rst_bus_busy", bus_busy, 0);
        check("rst_bus_free", bus_free, 0);
        check("rst_bit_data", bit_data, 0);
        rst = 1'b1;
        wait_cyc(469);
        check("free_before_470", bus_free, 0);
        wait_cyc(1);
        check("free_at_470", bus_free, 1);
        check("idle_busy", bus_busy, 0);

        // ---- 2: START from idle ----
        sda_in = 1'b0;
        push_ev(F_START, 1'b0, LAT);
        wait_cyc(LAT);
        check("busy_with_start", bus_busy, 0);
        wait_cyc(1);
        check("busy_after_start", bus_busy, 1);
        check("free_after_start", bus_free, 0);

        // ---- 3: byte 0xA5, MSB first, SCL 10 low / 10 high ----
        byte_val = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            scl_in = 1'b0;
            push_ev(F_FALL, 1'b0, LAT);
            wait_cyc(5);
            sda_in = byte_val[i];
            wait_cyc(5);
            scl_in = 1'b1;
            push_ev(F_RISE | F_BV, byte_val[i], LAT);
            wait_cyc(10);
        end
        check("bit_data_hold", bit_data, 1);
        check("busy_in_byte", bus_busy, 1);

        // ---- 4: repeated START, then STOP and tBUF ----
        sda_in = 1'b0;
        push_ev(F_START | F_RSTART, 1'b0, LAT);
        wait_cyc(10);
        check("busy_after_rstart", bus_busy, 1);
        sda_in = 1'b1;
        push_ev(F_STOP, 1'b0, LAT);
        wait_cyc(LAT);
        check("busy_with_stop", bus_busy, 1);
        wait_cyc(1);
        check("busy_after_stop", bus_busy, 0);
        wait_cyc(469);
        check("free_before_tbuf", bus_free, 0);
        wait_cyc(1);
        check("free_after_tbuf", bus_free, 1);

        // ---- 5: 3-cycle glitches rejected, 4-cycle pulses accepted ----
        scl_in = 1'b0;
        wait_cyc(3);
        scl_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(1);
            check("scl_glitch_filt", scl_filt, 1);
        end
        sda_in = 1'b0;
        wait_cyc(3);
        sda_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(1);
            check("sda_glitch_filt", sda_filt, 1);
        end
        check("glitch_busy", bus_busy, 0);

        sda_in = 1'b0;
        push_ev(F_START, 1'b0, LAT);
        wait_cyc(4);
        sda_in = 1'b1;
        push_ev(F_STOP, 1'b0, LAT);
        wait_cyc(2);
        check("sda_pulse4_filt", sda_filt, 0);
        wait_cyc(10);
        check("sda_pulse4_idle", bus_busy, 0);

        scl_in = 1'b0;
        push_ev(F_FALL, 1'b0, LAT);
        wait_cyc(4);
        scl_in = 1'b1;
        push_ev(F_RISE | F_BV, 1'b1, LAT);
        wait_cyc(2);
        check("scl_pulse4_filt", scl_filt, 0);
        wait_cyc(10);
        check("scl_pulse4_busy", bus_busy, 1);

        // ---- 6: reset mid-byte, recover via first SCL fall ----
        scl_in = 1'b0;
        push_ev(F_FALL, 1'b0, LAT);
        wait_cyc(10);
        scl_in = 1'b1;
        push_ev(F_RISE | F_BV, 1'b1, LAT);
        wait_cyc(10);
        scl_in = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        check("mid_rst_scl_filt", scl_filt, 1);
        check("mid_rst_sda_filt", sda_filt, 1);
        check("mid_rst_busy", bus_busy, 0);
        check("mid_rst_free", bus_free, 0);
        check("mid_rst_bit_data", bit_data, 0);
        check("mid_rst_pulses",
              {scl_rise, scl_fall, start_det, rstart_det, stop_det, bit_valid}, 0);
        wait_cyc(2);
        rst = 1'b1;
        push_ev(F_FALL, 1'b0, LAT);
        wait_cyc(LAT);
        check("resume_busy_early", bus_busy, 0);
        wait_cyc(1);
        check("resume_busy", bus_busy, 1);
        wait_cyc(5);
        scl_in = 1'b1;
        push_ev(F_RISE | F_BV, 1'b1, LAT);
        wait_cyc(15);

        s = exp_q.size();
        check("events_outstanding", s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
